// File: rtl/step_counter_pkg.sv
// Shared definitions for the step counter: direction and boundary-mode
// encodings plus the state encoding of the step-acceptance FSM.
package step_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // IDLE  : step seen low, the next synchronised rising edge is accepted
    // ARMED : an edge was consumed, waiting for the step line to drop
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } step_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the asynchronous step line, followed by a
// rising-edge detector gated by the IDLE/ARMED acceptance FSM.
// rise is high for one clock per accepted rising edge of 'in'.
module edge_sync
    import step_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic        r_sync0;
    logic        r_sync1;
    logic        r_prev;
    step_state_t r_state;
    logic        w_edge;

    assign w_edge = r_sync1 & ~r_prev;
    assign rise   = w_edge & (r_state == IDLE);

    // Synchronise the step line and keep the previous synchronised level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync0 <= in;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
        end
    end

    // Acceptance FSM: consume one edge, then wait for the synchronised release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_edge)   r_state <= ARMED;
                ARMED:   if (!r_sync1) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/step_counter.sv
// Modulo-MODULO up/down counter advanced by edges of an asynchronous step
// input. Per cycle priority is clear > load > step edge; lower-priority
// requests in the same cycle are dropped. Boundary crossing either wraps
// (with a one-cycle wrap pulse) or saturates, selected by mode.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int MODULO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    // Top count value and MODULO itself, sized so MODULO = 2^WIDTH still fits
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_VAL = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_rise;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (step),
        .rise (w_rise)
    );

    // Next-state selection: clear, then load (clamped), then step edge
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (clear) begin
            w_next_count = '0;
        end else if (load) begin
            if ({1'b0, load_val} >= MOD_VAL) begin
                w_next_count = MAX_VAL;
            end else begin
                w_next_count = load_val;
            end
        end else if (w_rise) begin
            if (dir == DIR_UP) begin
                if (r_count != MAX_VAL) begin
                    w_next_count = r_count + WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    w_next_count = '0;
                    w_next_wrap  = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_next_count = r_count - WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    w_next_count = MAX_VAL;
                    w_next_wrap  = 1'b1;
                end
            end
        end
    end

    // Count and wrap pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign count  = r_count;
    assign wrap   = r_wrap;
    assign at_max = (r_count == MAX_VAL);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: three instances (4/6/10 states) share one set of
// inputs; a behavioural model predicts every output after each clock.
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] lv4;
    logic       clear;

    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
    logic [3:0] cnt_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       max_a, max_b, max_c;
    logic       min_a, min_b, min_c;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int M [3] = '{4, 6, 10};
    int W [3] = '{2, 3, 4};
    int ec [3];
    int ew [3];
    bit h1, h2, h3;
    int wrap_seen [3];

    int exp35 [5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    step_counter #(.WIDTH(2), .MODULO(4)) dut_a (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .mode(mode),
        .load(load), .load_val(lv4[1:0]), .clear(clear),
        .count(cnt_a), .wrap(wrap_a), .at_max(max_a), .at_min(min_a)
    );

    step_counter #(.WIDTH(3), .MODULO(6)) dut_b (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .mode(mode),
        .load(load), .load_val(lv4[2:0]), .clear(clear),
        .count(cnt_b), .wrap(wrap_b), .at_max(max_b), .at_min(min_b)
    );

    step_counter #(.WIDTH(4), .MODULO(10)) dut_c (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .mode(mode),
        .load(load), .load_val(lv4), .clear(clear),
        .count(cnt_c), .wrap(wrap_c), .at_max(max_c), .at_min(min_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ec[i] = 0;
            ew[i] = 0;
        end
        h1 = 1'b0;
        h2 = 1'b0;
        h3 = 1'b0;
    endtask

    // An edge takes effect when step was sampled high two clocks ago and
    // low three clocks ago (samples before/through reset count as low).
    task automatic model_edge();
        bit e;
        if (rst) begin
            model_reset();
            return;
        end
        e = h2 && !h3;
        for (int i = 0; i < 3; i++) begin
            int lv;
            lv = int'(lv4) % (1 << W[i]);
            ew[i] = 0;
            if (clear) begin
                ec[i] = 0;
            end else if (load) begin
                ec[i] = (lv >= M[i]) ? M[i] - 1 : lv;
            end else if (e) begin
                if (dir == 1'b0) begin
                    if (ec[i] < M[i] - 1) ec[i]++;
                    else if (mode == 1'b0) begin ec[i] = 0; ew[i] = 1; end
                end else begin
                    if (ec[i] > 0) ec[i]--;
                    else if (mode == 1'b0) begin ec[i] = M[i] - 1; ew[i] = 1; end
                end
            end
        end
        h3 = h2;
        h2 = h1;
        h1 = step;
    endtask

    task automatic check_all();
        chk("count_a",  32'(cnt_a),  ec[0]);
        chk("wrap_a",   32'(wrap_a), ew[0]);
        chk("at_max_a", 32'(max_a),  32'(ec[0] == M[0] - 1));
        chk("at_min_a", 32'(min_a),  32'(ec[0] == 0));
        chk("count_b",  32'(cnt_b),  ec[1]);
        chk("wrap_b",   32'(wrap_b), ew[1]);
        chk("at_max_b", 32'(max_b),  32'(ec[1] == M[1] - 1));
        chk("at_min_b", 32'(min_b),  32'(ec[1] == 0));
        chk("count_c",  32'(cnt_c),  ec[2]);
        chk("wrap_c",   32'(wrap_c), ew[2]);
        chk("at_max_c", 32'(max_c),  32'(ec[2] == M[2] - 1));
        chk("at_min_c", 32'(min_c),  32'(ec[2] == 0));
    endtask

    // One clock: model update at the rising edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (wrap_a === 1'b1) wrap_seen[0]++;
        if (wrap_b === 1'b1) wrap_seen[1]++;
        if (wrap_c === 1'b1) wrap_seen[2]++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        step = 1'b1;
        ticks(2);
        step = 1'b0;
        ticks(3);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic clr_wrap_seen();
        for (int i = 0; i < 3; i++) wrap_seen[i] = 0;
    endtask

    initial begin
        rst   = 1'b1;
        step  = 1'b0;
        dir   = 1'b0;
        mode  = 1'b0;
        load  = 1'b0;
        lv4   = 4'd0;
        clear = 1'b0;
        model_reset();
        clr_wrap_seen();

        // reset state
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // four-state wrap counting up, five pulses
        dir = 1'b0; mode = 1'b0;
        clr_wrap_seen();
        for (int p = 0; p < 5; p++) begin
            pulse();
            chk("wrap_up_seq_a", 32'(cnt_a), exp35[p]);
        end
        chk("wrap_up_pulses_a", wrap_seen[0], 1);

        // six-state saturation at both ends
        do_clear();
        dir = 1'b1; mode = 1'b1;
        clr_wrap_seen();
        pulse();
        pulse();
        chk("sat_dn_b", 32'(cnt_b), 0);
        chk("sat_dn_nowrap_b", wrap_seen[1], 0);
        dir = 1'b0;
        for (int p = 0; p < 7; p++) pulse();
        chk("sat_up_b", 32'(cnt_b), 5);
        chk("sat_up_max_b", 32'(max_b), 1);
        chk("sat_up_nowrap_b", wrap_seen[1], 0);

        // step held high: one increment, two edges after assertion
        mode = 1'b0;
        do_clear();
        step = 1'b1;
        tick();
        chk("held_lat1_a", 32'(cnt_a), 0);
        tick();
        chk("held_lat2_a", 32'(cnt_a), 0);
        tick();
        chk("held_lat3_a", 32'(cnt_a), 1);
        ticks(17);
        step = 1'b0;
        ticks(3);
        chk("held_once_a", 32'(cnt_a), 1);

        // clear, load and edge together; then clamped load
        ticks(2);
        step = 1'b1; clear = 1'b1; load = 1'b1; lv4 = 4'd2;
        ticks(3);
        clear = 1'b0; load = 1'b0; step = 1'b0;
        tick();
        chk("prio_a", 32'(cnt_a), 0);
        chk("prio_c", 32'(cnt_c), 0);
        ticks(3);
        load = 1'b1; lv4 = 4'd7;
        tick();
        load = 1'b0;
        chk("clamp_a", 32'(cnt_a), 3);
        chk("clamp_b", 32'(cnt_b), 5);
        chk("load_c", 32'(cnt_c), 7);

        // reset with an edge in flight
        load = 1'b1; lv4 = 4'd2;
        tick();
        load = 1'b0;
        chk("pre_rst_a", 32'(cnt_a), 2);
        step = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step = 1'b0;
        tick();
        rst = 1'b0;
        ticks(4);
        chk("rst_drop_a", 32'(cnt_a), 0);

        // ten-state wrap going down from zero
        do_clear();
        dir = 1'b1; mode = 1'b0;
        clr_wrap_seen();
        pulse();
        chk("wrap_dn_c", 32'(cnt_c), 9);
        chk("wrap_dn_max_c", 32'(max_c), 1);
        chk("wrap_dn_pulse_c", wrap_seen[2], 1);

        // step high when reset releases counts as a fresh edge
        rst = 1'b1;
        step = 1'b1;
        tick();
        rst = 1'b0;
        ticks(4);
        step = 1'b0;
        ticks(3);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            rst = 1'b0;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 9) == 0) dir  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            load  = (r < 4);
            clear = (r >= 4 && r < 7);
            lv4   = 4'($urandom_range(0, 15));
            if (r >= 97) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all();
            end
            tick();
        end
        rst = 1'b0; load = 1'b0; clear = 1'b0;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
